// File: rtl/cdb_arbiter_if.sv
// Bundle of FU result inputs and CDB broadcast outputs for cdb_arbiter.
//   master: the FU/consumer side; drives fu_valid/fu_value/fu_rob_tag, observes fu_ready and cdb_*.
//   slave : the arbiter side; drives fu_ready and cdb_*.
// Width macros get defaults here when the core's global header is not present.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif

interface cdb_arbiter_if #(
   parameter int unsigned FU_NUM    = 4,
   parameter int unsigned CDB_PORTS = 1
);
   localparam int unsigned IDX_W = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;

   logic [FU_NUM-1:0]                        fu_valid;
   logic [FU_NUM-1:0][`XLEN-1:0]             fu_value;
   logic [FU_NUM-1:0][`ROB_TAG_LEN-1:0]      fu_rob_tag;
   logic [FU_NUM-1:0]                        fu_ready;

   logic [CDB_PORTS-1:0]                     cdb_valid;
   logic [CDB_PORTS-1:0][`XLEN-1:0]          cdb_value;
   logic [CDB_PORTS-1:0][`ROB_TAG_LEN-1:0]   cdb_rob_tag;
   logic [CDB_PORTS-1:0][IDX_W-1:0]          cdb_fu_idx;

   modport master (
      output fu_valid, fu_value, fu_rob_tag,
      input  fu_ready, cdb_valid, cdb_value, cdb_rob_tag, cdb_fu_idx
   );

   modport slave (
      input  fu_valid, fu_value, fu_rob_tag,
      output fu_ready, cdb_valid, cdb_value, cdb_rob_tag, cdb_fu_idx
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Buffered round-robin Common Data Bus arbiter.
// Each FU owns a DEPTH-entry result FIFO (valid/ready push). Every cycle up to CDB_PORTS
// non-empty FIFOs are granted in round-robin order starting at rr_ptr, and their head entries
// are loaded into registered broadcast ports.
// Ports:
//   clock  : single clock
//   reset  : synchronous active-high reset
//   squash : synchronous active-high flush (empties FIFOs, clears broadcast, rr_ptr <= 0)
//   bus    : cdb_arbiter_if slave (fu_valid/value/rob_tag in, fu_ready out, cdb_* out)

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif

module cdb_arbiter #(
   parameter int unsigned FU_NUM    = 4,
   parameter int unsigned CDB_PORTS = 1,
   parameter int unsigned DEPTH     = 2
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         squash,
   cdb_arbiter_if.slave bus
);
   localparam int unsigned IDX_W = (FU_NUM > 1) ? $clog2(FU_NUM) : 1;
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic [`XLEN-1:0]        mem_value_q [FU_NUM][DEPTH];
   logic [`ROB_TAG_LEN-1:0] mem_tag_q   [FU_NUM][DEPTH];
   logic [PTR_W-1:0]        rd_ptr_q    [FU_NUM];
   logic [PTR_W-1:0]        wr_ptr_q    [FU_NUM];
   logic [CNT_W-1:0]        count_q     [FU_NUM];
   logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;

   logic [FU_NUM-1:0] ready, non_empty, push, pop;

   logic [CDB_PORTS-1:0]                   cdb_valid_d, cdb_valid_q;
   logic [CDB_PORTS-1:0][`XLEN-1:0]        cdb_value_d, cdb_value_q;
   logic [CDB_PORTS-1:0][`ROB_TAG_LEN-1:0] cdb_tag_d, cdb_tag_q;
   logic [CDB_PORTS-1:0][IDX_W-1:0]        cdb_idx_d, cdb_idx_q;

   // Arbitration scratch
   logic        found;
   int unsigned pos;
   int unsigned last_fu;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
   endfunction

   // Ready looks only at the registered count, so a full FIFO refuses a push even if popped.
   always_comb begin
      ready     = '0;
      non_empty = '0;
      for (int unsigned f = 0; f < FU_NUM; f++) begin
         ready[f]     = (count_q[f] < CNT_W'(DEPTH));
         non_empty[f] = (count_q[f] != '0);
      end
   end

   assign push = bus.fu_valid & ready;

   // Port p takes the p-th non-empty FIFO found scanning from rr_ptr; pop marks FIFOs already
   // granted to a lower port so later ports skip them.
   always_comb begin
      pop         = '0;
      found       = 1'b0;
      pos         = 0;
      last_fu     = 0;
      cdb_valid_d = '0;
      cdb_value_d = '0;
      cdb_tag_d   = '0;
      cdb_idx_d   = '0;
      rr_ptr_d    = rr_ptr_q;
      for (int unsigned p = 0; p < CDB_PORTS; p++) begin
         found = 1'b0;
         for (int unsigned k = 0; k < FU_NUM; k++) begin
            pos = (32'(rr_ptr_q) + k) % FU_NUM;
            for (int unsigned f = 0; f < FU_NUM; f++) begin
               if (!found && (f == pos) && non_empty[f] && !pop[f]) begin
                  found          = 1'b1;
                  pop[f]         = 1'b1;
                  last_fu        = f;
                  cdb_valid_d[p] = 1'b1;
                  cdb_value_d[p] = mem_value_q[f][rd_ptr_q[f]];
                  cdb_tag_d[p]   = mem_tag_q[f][rd_ptr_q[f]];
                  cdb_idx_d[p]   = IDX_W'(f);
               end
            end
         end
      end
      if (|pop) begin
         rr_ptr_d = IDX_W'((last_fu + 1) % FU_NUM);
      end
   end

   always_ff @(posedge clock) begin
      if (reset || squash) begin
         rr_ptr_q    <= '0;
         cdb_valid_q <= '0;
         cdb_value_q <= '0;
         cdb_tag_q   <= '0;
         cdb_idx_q   <= '0;
         for (int unsigned f = 0; f < FU_NUM; f++) begin
            rd_ptr_q[f] <= '0;
            wr_ptr_q[f] <= '0;
            count_q[f]  <= '0;
         end
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_value_q <= cdb_value_d;
         cdb_tag_q   <= cdb_tag_d;
         cdb_idx_q   <= cdb_idx_d;
         for (int unsigned f = 0; f < FU_NUM; f++) begin
            if (push[f]) wr_ptr_q[f] <= ptr_inc(wr_ptr_q[f]);
            if (pop[f])  rd_ptr_q[f] <= ptr_inc(rd_ptr_q[f]);
            if (push[f] && !pop[f]) begin
               count_q[f] <= count_q[f] + CNT_W'(1);
            end else if (!push[f] && pop[f]) begin
               count_q[f] <= count_q[f] - CNT_W'(1);
            end
         end
      end
   end

   // Storage has no reset; validity is tracked by the pointers and counts.
   always_ff @(posedge clock) begin
      for (int unsigned f = 0; f < FU_NUM; f++) begin
         if (push[f] && !reset && !squash) begin
            mem_value_q[f][wr_ptr_q[f]] <= bus.fu_value[f];
            mem_tag_q[f][wr_ptr_q[f]]   <= bus.fu_rob_tag[f];
         end
      end
   end

   assign bus.fu_ready    = ready;
   assign bus.cdb_valid   = cdb_valid_q;
   assign bus.cdb_value   = cdb_value_q;
   assign bus.cdb_rob_tag = cdb_tag_q;
   assign bus.cdb_fu_idx  = cdb_idx_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: two instances (1 port/depth 2 and 2 ports/depth 3) driven side by side,
// directed scenarios with fixed expectations plus randomized traffic against a queue model.

`ifndef XLEN
`define XLEN 32
`endif
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 5
`endif

module tb_cdb_arbiter;
   localparam int XW = `XLEN;
   localparam int TW = `ROB_TAG_LEN;

   typedef struct packed {
      logic [XW-1:0] v;
      logic [TW-1:0] t;
   } entry_t;

   logic clock;
   logic reset;
   logic squash;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   cdb_arbiter_if #(.FU_NUM(4), .CDB_PORTS(1)) ia ();
   cdb_arbiter_if #(.FU_NUM(4), .CDB_PORTS(2)) ib ();

   cdb_arbiter #(.FU_NUM(4), .CDB_PORTS(1), .DEPTH(2)) dut_a (
      .clock (clock),
      .reset (reset),
      .squash(squash),
      .bus   (ia)
   );

   cdb_arbiter #(.FU_NUM(4), .CDB_PORTS(2), .DEPTH(3)) dut_b (
      .clock (clock),
      .reset (reset),
      .squash(squash),
      .bus   (ib)
   );

   int passed;
   int total;

   // Reference model: one queue per (instance, FU), plus the round-robin start position.
   entry_t                  mq [8][$];
   int                      mrr [2];
   logic [1:0]              ev  [2];
   logic [1:0][XW-1:0]      exp_value [2];
   logic [1:0][TW-1:0]      etag [2];
   logic [1:0][1:0]         eidx [2];

   task automatic model_edge(input int d, input int ports, input int depth,
                             input logic [3:0] v, input logic [3:0][XW-1:0] val,
                             input logic [3:0][TW-1:0] tag, input logic clear);
      bit rdy [4];
      bit popped [4];
      int n;
      int last;
      int f;
      entry_t e;
      ev[d]        = '0;
      exp_value[d] = '0;
      etag[d]      = '0;
      eidx[d]      = '0;
      if (clear) begin
         for (int i = 0; i < 4; i++) mq[d*4+i].delete();
         mrr[d] = 0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            rdy[i]    = (mq[d*4+i].size() < depth);
            popped[i] = 1'b0;
         end
         n    = 0;
         last = 0;
         for (int k = 0; k < 4; k++) begin
            f = (mrr[d] + k) % 4;
            if (n < ports && mq[d*4+f].size() > 0) begin
               ev[d][n]        = 1'b1;
               exp_value[d][n] = mq[d*4+f][0].v;
               etag[d][n]      = mq[d*4+f][0].t;
               eidx[d][n]      = f[1:0];
               popped[f]       = 1'b1;
               last            = f;
               n++;
            end
         end
         for (int i = 0; i < 4; i++) begin
            if (popped[i]) void'(mq[d*4+i].pop_front());
            if (v[i] && rdy[i]) begin
               e = {val[i], tag[i]};
               mq[d*4+i].push_back(e);
            end
         end
         if (n > 0) mrr[d] = (last + 1) % 4;
      end
   endtask

   function automatic logic [3:0] exp_ready(input int d, input int depth);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = (mq[d*4+i].size() < depth);
      return r;
   endfunction

   task automatic tick();
      model_edge(0, 1, 2, ia.fu_valid, ia.fu_value, ia.fu_rob_tag, reset || squash);
      model_edge(1, 2, 3, ib.fu_valid, ib.fu_value, ib.fu_rob_tag, reset || squash);
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      ia.fu_valid = '0; ia.fu_value = '0; ia.fu_rob_tag = '0;
      ib.fu_valid = '0; ib.fu_value = '0; ib.fu_rob_tag = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      squash = 1'b0;
      reset  = 1'b1;
      tick();
      reset  = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (ia.cdb_valid !== 1'b0) $display("FAIL reset_valid_a got %b want 0", ia.cdb_valid); else passed++;
      total++; if ({ia.cdb_value, ia.cdb_rob_tag, ia.cdb_fu_idx} !== '0) $display("FAIL reset_data_a got %h want 0", {ia.cdb_value, ia.cdb_rob_tag, ia.cdb_fu_idx}); else passed++;
      total++; if (ia.fu_ready !== 4'hF) $display("FAIL reset_ready_a got %b want 1111", ia.fu_ready); else passed++;
      total++; if (ib.cdb_valid !== 2'b00) $display("FAIL reset_valid_b got %b want 00", ib.cdb_valid); else passed++;
      total++; if (ib.fu_ready !== 4'hF) $display("FAIL reset_ready_b got %b want 1111", ib.fu_ready); else passed++;
   endtask

   task automatic test_single();
      do_reset();
      ia.fu_valid[2] = 1'b1; ia.fu_value[2] = 32'hDEAD_BEEF; ia.fu_rob_tag[2] = TW'(5);
      tick();
      clear_inputs();
      total++; if (ia.cdb_valid !== 1'b0) $display("FAIL single_nobypass got %b want 0", ia.cdb_valid); else passed++;
      tick();
      total++; if (ia.cdb_valid !== 1'b1) $display("FAIL single_valid got %b want 1", ia.cdb_valid); else passed++;
      total++; if (ia.cdb_value[0] !== 32'hDEAD_BEEF) $display("FAIL single_value got %h want deadbeef", ia.cdb_value[0]); else passed++;
      total++; if (ia.cdb_rob_tag[0] !== TW'(5)) $display("FAIL single_tag got %0d want 5", ia.cdb_rob_tag[0]); else passed++;
      total++; if (ia.cdb_fu_idx[0] !== 2'd2) $display("FAIL single_idx got %0d want 2", ia.cdb_fu_idx[0]); else passed++;
      tick();
      total++; if (ia.cdb_valid !== 1'b0) $display("FAIL single_drop got %b want 0", ia.cdb_valid); else passed++;
   endtask

   task automatic test_contention();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         ia.fu_valid[i] = 1'b1; ia.fu_value[i] = XW'(100 + i); ia.fu_rob_tag[i] = TW'(i);
      end
      tick();
      clear_inputs();
      for (int e = 0; e < 4; e++) begin
         tick();
         total++; if ({ia.cdb_valid, ia.cdb_fu_idx[0], ia.cdb_rob_tag[0]} !== {1'b1, 2'(e), TW'(e)})
            $display("FAIL contention_e%0d got v=%b idx=%0d tag=%0d want v=1 idx=%0d tag=%0d", e, ia.cdb_valid, ia.cdb_fu_idx[0], ia.cdb_rob_tag[0], e, e);
         else passed++;
      end
      // rr_ptr should be back at 0: FU0 wins over FU1 when both arrive together
      ia.fu_valid = 4'b0011;
      tick();
      clear_inputs();
      tick();
      total++; if (ia.cdb_fu_idx[0] !== 2'd0 || ia.cdb_valid !== 1'b1) $display("FAIL contention_rr got v=%b idx=%0d want v=1 idx=0", ia.cdb_valid, ia.cdb_fu_idx[0]); else passed++;
   endtask

   task automatic test_fairness();
      do_reset();
      ia.fu_valid = 4'b1001;
      tick();
      for (int n = 0; n < 8; n++) begin
         ia.fu_rob_tag[0] = TW'(n); ia.fu_rob_tag[3] = TW'(n + 16);
         tick();
         total++; if ({ia.cdb_valid, ia.cdb_fu_idx[0]} !== {1'b1, (n % 2 == 1) ? 2'd3 : 2'd0})
            $display("FAIL fairness_n%0d got v=%b idx=%0d want v=1 idx=%0d", n, ia.cdb_valid, ia.cdb_fu_idx[0], (n % 2 == 1) ? 3 : 0);
         else passed++;
      end
      clear_inputs();
   endtask

   task automatic test_backpressure();
      logic rdy1 [16];
      int   s;
      int   got[$];
      do_reset();
      s = 0;
      for (int c = 0; c < 16; c++) begin
         ia.fu_valid[0] = 1'b1; ia.fu_rob_tag[0] = TW'(1);
         ia.fu_valid[1] = (s < 3); ia.fu_rob_tag[1] = TW'(7 + s); ia.fu_value[1] = XW'(200 + s);
         rdy1[c] = ia.fu_ready[1];
         tick();
         if (rdy1[c] && s < 3) s++;
         if (ia.cdb_valid[0] && ia.cdb_fu_idx[0] == 2'd1) got.push_back(int'(ia.cdb_rob_tag[0]));
      end
      clear_inputs();
      total++; if (rdy1[1] !== 1'b1) $display("FAIL bp_ready_after1 got %b want 1", rdy1[1]); else passed++;
      total++; if (rdy1[2] !== 1'b0) $display("FAIL bp_ready_full got %b want 0", rdy1[2]); else passed++;
      total++; if (rdy1[3] !== 1'b1) $display("FAIL bp_ready_popped got %b want 1", rdy1[3]); else passed++;
      total++; if (got.size() != 3) $display("FAIL bp_count got %0d want 3", got.size()); else passed++;
      for (int i = 0; i < 3; i++) begin
         total++; if (got.size() <= i || got[i] != 7 + i) $display("FAIL bp_order_%0d got %0d want %0d", i, (got.size() > i) ? got[i] : -1, 7 + i); else passed++;
      end
   endtask

   task automatic test_multiport();
      do_reset();
      ib.fu_valid = 4'b1010; ib.fu_value[1] = 32'h11; ib.fu_value[3] = 32'h33;
      ib.fu_rob_tag[1] = TW'(1); ib.fu_rob_tag[3] = TW'(3);
      tick();
      clear_inputs();
      total++; if (ib.cdb_valid !== 2'b00) $display("FAIL mp_nobypass got %b want 00", ib.cdb_valid); else passed++;
      tick();
      total++; if (ib.cdb_valid !== 2'b11) $display("FAIL mp_valid got %b want 11", ib.cdb_valid); else passed++;
      total++; if (ib.cdb_fu_idx !== 4'b1101) $display("FAIL mp_idx got %b want 1101", ib.cdb_fu_idx); else passed++;
      total++; if (ib.cdb_value !== {32'h33, 32'h11}) $display("FAIL mp_value got %h want 0000003300000011", ib.cdb_value); else passed++;
      ib.fu_valid = 4'b0101;
      tick();
      clear_inputs();
      total++; if (ib.cdb_valid !== 2'b00) $display("FAIL mp_idle got %b want 00", ib.cdb_valid); else passed++;
      tick();
      total++; if ({ib.cdb_valid, ib.cdb_fu_idx} !== {2'b11, 4'b1000}) $display("FAIL mp_rr got v=%b idx=%b want v=11 idx=1000", ib.cdb_valid, ib.cdb_fu_idx); else passed++;
   endtask

   task automatic test_flush(input bit use_reset);
      do_reset();
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < 4; i++) begin
            ia.fu_valid[i] = 1'b1; ia.fu_value[i] = XW'(c * 4 + i); ia.fu_rob_tag[i] = TW'(c * 4 + i);
            ib.fu_valid[i] = 1'b1; ib.fu_value[i] = XW'(c * 4 + i); ib.fu_rob_tag[i] = TW'(c * 4 + i);
         end
         tick();
      end
      total++; if (ia.fu_ready !== exp_ready(0, 2)) $display("FAIL flush%0d_fill got %b want %b", use_reset, ia.fu_ready, exp_ready(0, 2)); else passed++;
      for (int i = 0; i < 4; i++) begin
         ia.fu_value[i] = 32'hBAD0_0000 | XW'(i); ia.fu_rob_tag[i] = TW'(31);
         ib.fu_value[i] = 32'hBAD0_0000 | XW'(i); ib.fu_rob_tag[i] = TW'(31);
      end
      if (use_reset) reset = 1'b1; else squash = 1'b1;
      tick();
      reset  = 1'b0;
      squash = 1'b0;
      clear_inputs();
      total++; if (ia.cdb_valid !== 1'b0 || ib.cdb_valid !== 2'b00) $display("FAIL flush%0d_valid got a=%b b=%b want 0", use_reset, ia.cdb_valid, ib.cdb_valid); else passed++;
      total++; if (ia.fu_ready !== 4'hF || ib.fu_ready !== 4'hF) $display("FAIL flush%0d_ready got a=%b b=%b want 1111", use_reset, ia.fu_ready, ib.fu_ready); else passed++;
      total++; if ({ia.cdb_value, ia.cdb_rob_tag, ib.cdb_value, ib.cdb_rob_tag} !== '0) $display("FAIL flush%0d_data got nonzero want 0", use_reset); else passed++;
      for (int c = 0; c < 5; c++) begin
         tick();
         total++; if ({ia.cdb_valid, ib.cdb_valid} !== 3'b000) $display("FAIL flush%0d_quiet_c%0d got a=%b b=%b want 0", use_reset, c, ia.cdb_valid, ib.cdb_valid); else passed++;
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         squash = ($urandom_range(0, 39) == 0);
         for (int i = 0; i < 4; i++) begin
            ia.fu_valid[i] = ($urandom_range(0, 2) != 0); ia.fu_value[i] = XW'($urandom); ia.fu_rob_tag[i] = TW'($urandom);
            ib.fu_valid[i] = ($urandom_range(0, 1) != 0); ib.fu_value[i] = XW'($urandom); ib.fu_rob_tag[i] = TW'($urandom);
         end
         tick();
         total++; if ({ia.cdb_valid, ia.cdb_value, ia.cdb_rob_tag, ia.cdb_fu_idx} !== {ev[0][0], exp_value[0][0], etag[0][0], eidx[0][0]})
            $display("FAIL rand_cdb_a c%0d got %h want %h", c, {ia.cdb_valid, ia.cdb_value, ia.cdb_rob_tag, ia.cdb_fu_idx}, {ev[0][0], exp_value[0][0], etag[0][0], eidx[0][0]});
         else passed++;
         total++; if ({ib.cdb_valid, ib.cdb_value, ib.cdb_rob_tag, ib.cdb_fu_idx} !== {ev[1], exp_value[1], etag[1], eidx[1]})
            $display("FAIL rand_cdb_b c%0d got %h want %h", c, {ib.cdb_valid, ib.cdb_value, ib.cdb_rob_tag, ib.cdb_fu_idx}, {ev[1], exp_value[1], etag[1], eidx[1]});
         else passed++;
         total++; if (ia.fu_ready !== exp_ready(0, 2)) $display("FAIL rand_ready_a c%0d got %b want %b", c, ia.fu_ready, exp_ready(0, 2)); else passed++;
         total++; if (ib.fu_ready !== exp_ready(1, 3)) $display("FAIL rand_ready_b c%0d got %b want %b", c, ib.fu_ready, exp_ready(1, 3)); else passed++;
      end
      squash = 1'b0;
      clear_inputs();
   endtask

   initial begin
      passed = 0;
      total  = 0;
      reset  = 1'b1;
      squash = 1'b0;
      clear_inputs();
      tick();
      test_reset();
      test_single();
      test_contention();
      test_fairness();
      test_backpressure();
      test_multiport();
      test_flush(1'b0);
      test_flush(1'b1);
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
